alu16_mul_seq: RTL and testbench



---
 rtl/alu16_mul_seq.sv | 163 ++++++++++++++++
 tb/tb_alu16_mul_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu16_mul_seq.sv
// rtl/alu16_mul_seq.sv - 16x16 unsigned shift-and-add multiply sequencer around one ALU16Bit
// Build option: ALU_MUL_ZERO_BYPASS_EN finishes a multiply with a zero operand in one cycle.

// Small 16-bit ALU slice: AND/OR/ADD/SLT, with b inversion (op[2]) for subtract.
module ALU16Bit (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [2:0]  op_i,
  input  logic        cin_i,
  input  logic        less_i,
  output logic [15:0] result_o,
  output logic        cout_o,
  output logic        set_o,
  output logic        zero_o,
  output logic        g_o,
  output logic        p_o,
  output logic        overflow_o
);
  logic [15:0] b_eff;
  logic        cin_eff;
  logic [16:0] sum;
  logic [16:0] sum_nc;

  assign b_eff   = op_i[2] ? ~b_i : b_i;
  assign cin_eff = cin_i | op_i[2];
  assign sum     = {1'b0, a_i} + {1'b0, b_eff} + {16'd0, cin_eff};
  assign sum_nc  = {1'b0, a_i} + {1'b0, b_eff};

  assign cout_o     = sum[16];
  assign overflow_o = (a_i[15] == b_eff[15]) && (sum[15] != a_i[15]);
  assign set_o      = sum[15] ^ overflow_o;
  assign g_o        = sum_nc[16];
  assign p_o        = &(a_i ^ b_eff);
  assign zero_o     = (result_o == 16'd0);

  // Function select on the low two opcode bits.
  always_comb begin
    result_o = 16'd0;
    case (op_i[1:0])
      2'b00:   result_o = a_i & b_eff;
      2'b01:   result_o = a_i | b_eff;
      2'b10:   result_o = sum[15:0];
      default: result_o = {15'd0, less_i};
    endcase
  end
endmodule

module alu16_mul_seq (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      state_q;
  logic [15:0] mcand_q;
  logic [15:0] hi_q;
  logic [15:0] lo_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] product_q;

  logic [15:0] hi_d;
  logic [15:0] lo_d;
  logic [15:0] alu_result;
  logic        alu_cout;
  logic        alu_set_unused;
  logic        alu_zero_unused;
  logic        alu_g_unused;
  logic        alu_p_unused;
  logic        alu_overflow_unused;
  logic        bypass;

`ifdef ALU_MUL_ZERO_BYPASS_EN
  assign bypass = (a_i == 16'd0) || (b_i == 16'd0);
`else
  assign bypass = 1'b0;
`endif

  ALU16Bit u_alu (
    .a_i        (hi_q),
    .b_i        (mcand_q),
    .op_i       (3'b010),
    .cin_i      (1'b0),
    .less_i     (1'b0),
    .result_o   (alu_result),
    .cout_o     (alu_cout),
    .set_o      (alu_set_unused),
    .zero_o     (alu_zero_unused),
    .g_o        (alu_g_unused),
    .p_o        (alu_p_unused),
    .overflow_o (alu_overflow_unused)
  );

  // One shift-and-add step: add multiplicand when the current multiplier bit is set, then shift right with carry into hi[15].
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (lo_q[0]) begin
      {hi_d, lo_d} = {alu_cout, alu_result, lo_q[15:1]};
    end else begin
      {hi_d, lo_d} = {1'b0, hi_q, lo_q[15:1]};
    end
  end

  // Control FSM with registered busy/done/product; reset has priority over start.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      mcand_q   <= 16'd0;
      hi_q      <= 16'd0;
      lo_q      <= 16'd0;
      cnt_q     <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= 32'd0;
    end else begin
      case (state_q)
        S_CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            state_q   <= S_DONE;
            product_q <= {hi_d, lo_d};
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start_i) begin
            mcand_q <= a_i;
            lo_q    <= b_i;
            hi_q    <= 16'd0;
            cnt_q   <= 5'd0;
            if (bypass) begin
              state_q   <= S_DONE;
              product_q <= 32'd0;
              done_q    <= 1'b1;
            end else begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = product_q;
endmodule

// File: tb/tb_alu16_mul_seq.sv
// tb/tb_alu16_mul_seq.sv - scoreboard bench for alu16_mul_seq
module tb_alu16_mul_seq;
  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] product_o;

  alu16_mul_seq dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .product_o (product_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int prev_done_cyc = 0;
  int busy_run = 0;
  int last_busy = 0;
  int busy_total = 0;
  int start_cyc = 0;
  logic [31:0] exp_q[$];

`ifdef ALU_MUL_ZERO_BYPASS_EN
  localparam int ZERO_OFFSET = 0;
  localparam int ZERO_BUSY   = 0;
`else
  localparam int ZERO_OFFSET = 16;
  localparam int ZERO_BUSY   = 16;
`endif

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
    end
  endtask

  // Monitor: tracks busy runs and pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (busy_o) begin
      busy_run++;
      busy_total++;
    end else if (busy_run != 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
    if (busy_o && done_o) chk("busy_done_overlap", 32'd1, 32'd0);
    if (done_o) begin
      prev_done_cyc = done_cyc;
      done_cyc      = cyc;
      done_cnt++;
      if (exp_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else chk("product", product_o, exp_q.pop_front());
    end
  end

  task automatic do_start(input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] want, input bit hold);
    @(negedge clk);
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
    exp_q.push_back(want);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    if (!hold) start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    int k;
    n0 = done_cnt;
    k  = 0;
    while (done_cnt == n0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (done_cnt == n0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n0;
    int bt0;
    reset_i = 1'b1;
    start_i = 1'b0;
    a_i     = 16'd0;
    b_i     = 16'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_done", {31'd0, done_o}, 32'd0);
    chk("reset_product", product_o, 32'd0);
    reset_i = 1'b0;

    // 3 * 5
    do_start(16'd3, 16'd5, 32'd15, 1'b0);
    wait_done(40);
    chk("lat_3x5", done_cyc - start_cyc, 32'd16);
    chk("busy_len_3x5", last_busy, 32'd16);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("hold_product", product_o, 32'd15);
      chk("hold_no_done", {31'd0, done_o}, 32'd0);
    end

    // Carry out shifted into hi
    do_start(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0);
    wait_done(40);

    // Held start, operands changed mid-run, restart from DONE
    do_start(16'h1234, 16'h00FF, 32'h001221CC, 1'b1);
    repeat (6) @(negedge clk);
    a_i = 16'd7;
    b_i = 16'd9;
    wait_done(40);
    exp_q.push_back(32'd63);
    @(negedge clk);
    start_i = 1'b0;
    wait_done(40);
    chk("restart_gap", done_cyc - prev_done_cyc, 32'd17);

    // Reset in the middle of CALC
    do_start(16'd100, 16'd200, 32'd20000, 1'b0);
    repeat (8) @(negedge clk);
    reset_i = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("midreset_busy", {31'd0, busy_o}, 32'd0);
    chk("midreset_done", {31'd0, done_o}, 32'd0);
    chk("midreset_product", product_o, 32'd0);
    reset_i = 1'b0;
    n0 = done_cnt;
    repeat (25) @(negedge clk);
    chk("no_done_after_reset", done_cnt - n0, 32'd0);
    do_start(16'd100, 16'd200, 32'd20000, 1'b0);
    wait_done(40);

    // Zero operand
    bt0 = busy_total;
    do_start(16'd0, 16'h8001, 32'd0, 1'b0);
    wait_done(40);
    chk("zero_done_offset", done_cyc - start_cyc, ZERO_OFFSET);
    chk("zero_busy_cycles", busy_total - bt0, ZERO_BUSY);

    // Upper-half boundary
    do_start(16'h8000, 16'd2, 32'h00010000, 1'b0);
    wait_done(40);

    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
